// File: rtl/snake_pkg.sv
// snake_pkg
// Shared definitions for the snake-body engine: direction and state
// encodings, default grid size, the barrier cell list and the initial
// head position. Also carries small helpers used by the engine and the
// next-head calculator.
package snake_pkg;

    // Direction encoding. Opposite directions differ only in bit 1.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    // Game-body state encoding, also driven straight out on state_o.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    localparam int GRID_W = 10;
    localparam int GRID_H = 8;

    // Barrier cells, packed 4 bits per cell: (3,2) (4,2) (5,2) (6,2).
    localparam int NUM_BARRIERS = 4;
    localparam logic [4*NUM_BARRIERS-1:0] BARRIER_X = {4'd6, 4'd5, 4'd4, 4'd3};
    localparam logic [4*NUM_BARRIERS-1:0] BARRIER_Y = {4'd2, 4'd2, 4'd2, 4'd2};

    localparam logic [3:0] INIT_HEAD_X = 4'd2;
    localparam logic [3:0] INIT_HEAD_Y = 4'd4;

    // True when a is the exact opposite of b.
    function automatic logic is_reverse(input dir_t a, input dir_t b);
        return a == dir_t'(b ^ 2'd2);
    endfunction

    // True when the signed candidate cell lands on any barrier cell.
    function automatic logic is_barrier(input logic signed [4:0] x,
                                        input logic signed [4:0] y);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_BARRIERS; k++) begin
            if (x == $signed({1'b0, BARRIER_X[4*k +: 4]}) &&
                y == $signed({1'b0, BARRIER_Y[4*k +: 4]}))
                hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/snake_next_head.sv
// snake_next_head
// Combinational next-head calculator. Moves the head one cell along the
// given direction using 5-bit signed arithmetic so that stepping off the
// left or top edge produces -1, then flags wall and barrier hits.
// Ports:
//   head_x, head_y   current head cell
//   dir              direction to move (snake_pkg::dir_t encoding)
//   nh_x, nh_y       candidate head cell, signed
//   wall_hit         candidate lies outside the grid
//   barrier_hit      candidate lies on a barrier cell
module snake_next_head #(
    parameter int GRID_W = snake_pkg::GRID_W,
    parameter int GRID_H = snake_pkg::GRID_H
) (
    input  logic [3:0]        head_x,
    input  logic [3:0]        head_y,
    input  logic [1:0]        dir,
    output logic signed [4:0] nh_x,
    output logic signed [4:0] nh_y,
    output logic              wall_hit,
    output logic              barrier_hit
);
    import snake_pkg::*;

    localparam logic signed [4:0] X_MAX = 5'(GRID_W - 1);
    localparam logic signed [4:0] Y_MAX = 5'(GRID_H - 1);

    // Step one cell on the committed axis, then classify the result.
    always_comb begin
        nh_x = $signed({1'b0, head_x});
        nh_y = $signed({1'b0, head_y});
        case (dir_t'(dir))
            DIR_UP:    nh_y = nh_y - 5'sd1;
            DIR_RIGHT: nh_x = nh_x + 5'sd1;
            DIR_DOWN:  nh_y = nh_y + 5'sd1;
            default:   nh_x = nh_x - 5'sd1;
        endcase
        wall_hit    = (nh_x < 5'sd0) || (nh_x > X_MAX) ||
                      (nh_y < 5'sd0) || (nh_y > Y_MAX);
        barrier_hit = is_barrier(nh_x, nh_y);
    end

endmodule

// File: rtl/snake_body.sv
// snake_body
// Snake-body state engine. On each move tick in RUN it advances the head,
// shifts the body, applies fruit growth or poison shrink, and detects death
// from walls, barriers and self-collision. Slots at or beyond the current
// length always mirror the tail so the display never shows stale cells.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start                         reload the init image and enter RUN
//   step                          one-cycle move tick
//   dir_in, dir_valid             requested direction and its qualifier
//   fruit_x/y, poison_x/y         item cells
//   snake_x_o, snake_y_o          packed segment coords, segment 0 = head
//   length_o                      current length
//   eat_o, poison_o               one-cycle item pulses
//   dead_o, state_o               DEAD level and FSM state
module snake_body #(
    parameter int MAX_LEN  = 10,
    parameter int GRID_W   = snake_pkg::GRID_W,
    parameter int GRID_H   = snake_pkg::GRID_H,
    parameter int INIT_LEN = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 step,
    input  logic [1:0]           dir_in,
    input  logic                 dir_valid,
    input  logic [3:0]           fruit_x,
    input  logic [3:0]           fruit_y,
    input  logic [3:0]           poison_x,
    input  logic [3:0]           poison_y,
    output logic [4*MAX_LEN-1:0] snake_x_o,
    output logic [4*MAX_LEN-1:0] snake_y_o,
    output logic [3:0]           length_o,
    output logic                 eat_o,
    output logic                 poison_o,
    output logic                 dead_o,
    output logic [1:0]           state_o
);
    import snake_pkg::*;

    localparam logic [3:0] MAX_LEN_L  = 4'(MAX_LEN);
    localparam logic [3:0] INIT_LEN_L = 4'(INIT_LEN);

    state_t            state_r, state_nx;
    dir_t              dir_r, dir_nx, dir_req_r, dir_req_nx, step_dir;
    logic [3:0]        seg_x_r  [MAX_LEN];
    logic [3:0]        seg_y_r  [MAX_LEN];
    logic [3:0]        seg_x_nx [MAX_LEN];
    logic [3:0]        seg_y_nx [MAX_LEN];
    logic [3:0]        init_x   [MAX_LEN];
    logic [3:0]        init_y   [MAX_LEN];
    logic [3:0]        sh_x     [MAX_LEN];
    logic [3:0]        sh_y     [MAX_LEN];
    logic [3:0]        mv_x     [MAX_LEN];
    logic [3:0]        mv_y     [MAX_LEN];
    logic [3:0]        len_r, len_nx, len_step, tail_idx;
    logic              eat_r, eat_nx, poison_r, poison_nx;
    logic              dir_ok;
    logic signed [4:0] nh_x, nh_y;
    logic              wall_hit, barrier_hit;
    logic              fruit_hit, poison_hit, grow, self_hit, fatal;

    // Init image: head at INIT_LEN-1 on row 4, body trailing left, unused
    // slots parked on the tail cell.
    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < INIT_LEN)
                init_x[i] = INIT_HEAD_X - 4'(i);
            else
                init_x[i] = INIT_HEAD_X - 4'(INIT_LEN - 1);
            init_y[i] = INIT_HEAD_Y;
        end
    end

    // A request that would reverse the committed direction is dropped, so
    // the snake can never fold back onto its own neck. A request arriving
    // with a step applies to that same step.
    assign dir_ok   = dir_valid && !is_reverse(dir_t'(dir_in), dir_r);
    assign step_dir = dir_ok ? dir_t'(dir_in) : dir_req_r;

    snake_next_head #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H)
    ) u_next_head (
        .head_x      (seg_x_r[0]),
        .head_y      (seg_y_r[0]),
        .dir         (step_dir),
        .nh_x        (nh_x),
        .nh_y        (nh_y),
        .wall_hit    (wall_hit),
        .barrier_hit (barrier_hit)
    );

    // Item and collision classification of the candidate head. The tail
    // slot is excluded from self-collision unless the body is growing,
    // because a non-growing tail vacates its cell on this very step.
    always_comb begin
        fruit_hit  = (nh_x == $signed({1'b0, fruit_x})) &&
                     (nh_y == $signed({1'b0, fruit_y}));
        poison_hit = !fruit_hit &&
                     (nh_x == $signed({1'b0, poison_x})) &&
                     (nh_y == $signed({1'b0, poison_y}));
        grow       = fruit_hit && (len_r < MAX_LEN_L);
        self_hit   = 1'b0;
        for (int j = 0; j < MAX_LEN; j++) begin
            if ((4'(j) < len_r) && (grow || (4'(j) != len_r - 4'd1)) &&
                (nh_x == $signed({1'b0, seg_x_r[j]})) &&
                (nh_y == $signed({1'b0, seg_y_r[j]})))
                self_hit = 1'b1;
        end
        fatal = wall_hit || barrier_hit || self_hit ||
                (poison_hit && (len_r == 4'd1));
    end

    // Shift the body by one slot behind the new head, then re-park every
    // slot past the new tail onto the tail cell.
    always_comb begin
        if (grow)
            len_step = len_r + 4'd1;
        else if (poison_hit)
            len_step = len_r - 4'd1;
        else
            len_step = len_r;
        tail_idx = len_step - 4'd1;
        sh_x[0]  = nh_x[3:0];
        sh_y[0]  = nh_y[3:0];
        for (int i = 1; i < MAX_LEN; i++) begin
            sh_x[i] = seg_x_r[i-1];
            sh_y[i] = seg_y_r[i-1];
        end
        for (int i = 0; i < MAX_LEN; i++) begin
            if (4'(i) > tail_idx) begin
                mv_x[i] = sh_x[tail_idx];
                mv_y[i] = sh_y[tail_idx];
            end else begin
                mv_x[i] = sh_x[i];
                mv_y[i] = sh_y[i];
            end
        end
    end

    // Next-state logic. start re-initialises from any state and wins over
    // a coincident step; steps only act in RUN, and a fatal step freezes
    // the body and moves to DEAD without any item pulse.
    always_comb begin
        state_nx   = state_r;
        dir_nx     = dir_r;
        dir_req_nx = dir_req_r;
        seg_x_nx   = seg_x_r;
        seg_y_nx   = seg_y_r;
        len_nx     = len_r;
        eat_nx     = 1'b0;
        poison_nx  = 1'b0;
        if (dir_ok)
            dir_req_nx = dir_t'(dir_in);
        if (start) begin
            state_nx   = ST_RUN;
            dir_nx     = DIR_RIGHT;
            dir_req_nx = DIR_RIGHT;
            seg_x_nx   = init_x;
            seg_y_nx   = init_y;
            len_nx     = INIT_LEN_L;
        end else if ((state_r == ST_RUN) && step) begin
            dir_nx = step_dir;
            if (fatal) begin
                state_nx = ST_DEAD;
            end else begin
                seg_x_nx  = mv_x;
                seg_y_nx  = mv_y;
                len_nx    = len_step;
                eat_nx    = fruit_hit;
                poison_nx = poison_hit;
            end
        end
    end

    // State register; reset loads the init image and parks in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            dir_r     <= DIR_RIGHT;
            dir_req_r <= DIR_RIGHT;
            seg_x_r   <= init_x;
            seg_y_r   <= init_y;
            len_r     <= INIT_LEN_L;
            eat_r     <= 1'b0;
            poison_r  <= 1'b0;
        end else begin
            state_r   <= state_nx;
            dir_r     <= dir_nx;
            dir_req_r <= dir_req_nx;
            seg_x_r   <= seg_x_nx;
            seg_y_r   <= seg_y_nx;
            len_r     <= len_nx;
            eat_r     <= eat_nx;
            poison_r  <= poison_nx;
        end
    end

    // Pack the segment registers onto the display buses.
    for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
        assign snake_x_o[4*g +: 4] = seg_x_r[g];
        assign snake_y_o[4*g +: 4] = seg_y_r[g];
    end

    assign length_o = len_r;
    assign eat_o    = eat_r;
    assign poison_o = poison_r;
    assign dead_o   = (state_r == ST_DEAD);
    assign state_o  = state_r;

endmodule

// File: tb/tb_snake_body.sv
// tb_snake_body
// Scoreboard bench for snake_body. Each cycle of stimulus is fed through a
// queue-based reference model of the snake; the predicted outputs are
// pushed to a scoreboard and compared against the DUT after the edge.
module tb_snake_body;

    logic        clk = 1'b0;
    logic        rst, start, step, dir_valid;
    logic [1:0]  dir_in;
    logic [3:0]  fruit_x, fruit_y, poison_x, poison_y;
    logic [39:0] snake_x_o, snake_y_o;
    logic [3:0]  length_o;
    logic        eat_o, poison_o, dead_o;
    logic [1:0]  state_o;

    typedef struct {
        string       tag;
        logic [39:0] ex;
        logic [39:0] ey;
        logic [3:0]  len;
        logic        eat;
        logic        pois;
        logic        dead;
        logic [1:0]  st;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    int mx[$];
    int my[$];
    int mdir, mreq, mstate;
    bit meat, mpois;

    snake_body dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .step      (step),
        .dir_in    (dir_in),
        .dir_valid (dir_valid),
        .fruit_x   (fruit_x),
        .fruit_y   (fruit_y),
        .poison_x  (poison_x),
        .poison_y  (poison_y),
        .snake_x_o (snake_x_o),
        .snake_y_o (snake_y_o),
        .length_o  (length_o),
        .eat_o     (eat_o),
        .poison_o  (poison_o),
        .dead_o    (dead_o),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_init();
        mx   = '{2, 1, 0};
        my   = '{4, 4, 4};
        mdir = 1;
        mreq = 1;
    endtask

    // Reference model of one clock cycle.
    task automatic model_cycle(input bit r, input bit s, input bit st,
                               input bit dv, input int din);
        bit ok, fr, ps, grow, die;
        int sd, hx, hy, limit;
        meat  = 1'b0;
        mpois = 1'b0;
        if (r) begin
            model_init();
            mstate = 0;
            return;
        end
        ok = dv && (din != ((mdir + 2) % 4));
        sd = ok ? din : mreq;
        if (ok) mreq = din;
        if (s) begin
            model_init();
            mstate = 1;
        end else if (mstate == 1 && st) begin
            mdir = sd;
            hx   = mx[0] + ((sd == 1) ? 1 : 0) - ((sd == 3) ? 1 : 0);
            hy   = my[0] + ((sd == 2) ? 1 : 0) - ((sd == 0) ? 1 : 0);
            fr   = (hx == int'(fruit_x)) && (hy == int'(fruit_y));
            ps   = !fr && (hx == int'(poison_x)) && (hy == int'(poison_y));
            grow = fr && (mx.size() < 10);
            die  = (hx < 0) || (hx > 9) || (hy < 0) || (hy > 7) ||
                   ((hy == 2) && (hx >= 3) && (hx <= 6)) ||
                   (ps && (mx.size() == 1));
            limit = grow ? mx.size() : mx.size() - 1;
            for (int j = 0; j < limit; j++)
                if (mx[j] == hx && my[j] == hy) die = 1'b1;
            if (die) begin
                mstate = 2;
            end else begin
                mx.push_front(hx);
                my.push_front(hy);
                if (!grow) begin
                    void'(mx.pop_back());
                    void'(my.pop_back());
                end
                if (ps) begin
                    void'(mx.pop_back());
                    void'(my.pop_back());
                end
                meat  = fr;
                mpois = ps;
            end
        end
    endtask

    function automatic logic [39:0] pack(input int q[$]);
        logic [39:0] v;
        int          c;
        v = '0;
        for (int i = 0; i < 10; i++) begin
            c = (i < q.size()) ? q[i] : q[q.size() - 1];
            v[4*i +: 4] = 4'(c);
        end
        return v;
    endfunction

    // Drive one cycle, predict, push, then pop and compare after the edge.
    task automatic applyStimulus(input bit r, input bit s, input bit st,
                                 input bit dv, input logic [1:0] din,
                                 input string tag);
        exp_t e;
        @(negedge clk);
        rst       = r;
        start     = s;
        step      = st;
        dir_valid = dv;
        dir_in    = din;
        model_cycle(r, s, st, dv, int'(din));
        e.tag  = tag;
        e.ex   = pack(mx);
        e.ey   = pack(my);
        e.len  = 4'(mx.size());
        e.eat  = meat;
        e.pois = mpois;
        e.dead = (mstate == 2);
        e.st   = 2'(mstate);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            checkOutput({e.tag, ".x"},      64'(snake_x_o), 64'(e.ex));
            checkOutput({e.tag, ".y"},      64'(snake_y_o), 64'(e.ey));
            checkOutput({e.tag, ".len"},    64'(length_o),  64'(e.len));
            checkOutput({e.tag, ".eat"},    64'(eat_o),     64'(e.eat));
            checkOutput({e.tag, ".poison"}, 64'(poison_o),  64'(e.pois));
            checkOutput({e.tag, ".dead"},   64'(dead_o),    64'(e.dead));
            checkOutput({e.tag, ".state"},  64'(state_o),   64'(e.st));
        end
    endtask

    task automatic idleCycle(input string tag);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, tag);
    endtask

    task automatic stepCycle(input string tag);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, tag);
    endtask

    task automatic startCycle(input string tag);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, tag);
    endtask

    task automatic turnStep(input logic [1:0] d, input string tag);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, d, tag);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; step = 1'b0; dir_valid = 1'b0; dir_in = 2'd0;
        fruit_x = 4'hF; fruit_y = 4'hF; poison_x = 4'hF; poison_y = 4'hF;
        model_init();
        mstate = 0;

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, "reset");
        stepCycle("idle_step_ignored");
        startCycle("start");
        repeat (3) stepCycle("run_right");
        idleCycle("run_hold");

        startCycle("restart_eat");
        fruit_x = 4'd3; fruit_y = 4'd4;
        stepCycle("eat");
        fruit_x = 4'hF; fruit_y = 4'hF;
        stepCycle("after_eat");

        startCycle("restart_dir");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, "reverse_dropped");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, "request_up");
        stepCycle("turn_up");

        startCycle("restart_barrier");
        turnStep(2'd0, "up_with_step");
        stepCycle("up_again");
        turnStep(2'd1, "into_barrier");
        stepCycle("dead_frozen");
        stepCycle("dead_frozen2");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, "start_beats_step");

        turnStep(2'd0, "wall_up");
        repeat (4) stepCycle("wall_climb");

        startCycle("restart_poison");
        poison_x = 4'd3; poison_y = 4'd4;
        stepCycle("poison_len3");
        poison_x = 4'd4;
        stepCycle("poison_len2");
        poison_x = 4'd5;
        stepCycle("poison_len1");
        poison_x = 4'hF; poison_y = 4'hF;

        startCycle("restart_same_cell");
        fruit_x = 4'd3; fruit_y = 4'd4; poison_x = 4'd3; poison_y = 4'd4;
        stepCycle("fruit_beats_poison");
        fruit_x = 4'hF; fruit_y = 4'hF; poison_x = 4'hF; poison_y = 4'hF;

        startCycle("restart_grow");
        for (int k = 3; k <= 9; k++) begin
            fruit_x = 4'(k); fruit_y = 4'd4;
            stepCycle("grow");
        end
        fruit_x = 4'd9; fruit_y = 4'd3;
        turnStep(2'd0, "eat_saturated");
        fruit_x = 4'hF; fruit_y = 4'hF;
        turnStep(2'd3, "turn_left");
        turnStep(2'd2, "self_hit");

        startCycle("restart_tail");
        fruit_x = 4'd3; fruit_y = 4'd4;
        stepCycle("tail_grow");
        fruit_x = 4'hF; fruit_y = 4'hF;
        turnStep(2'd0, "tail_up");
        turnStep(2'd3, "tail_left");
        turnStep(2'd2, "tail_chase");
        stepCycle("tail_continue");

        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, "reset_mid_step");
        idleCycle("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snake_body.md
# snake_body

Snake-body state engine for the final-project game. On each move tick it advances the head one grid cell, shifts the body, applies growth or shrink from fruit or poison, and detects death from walls, barriers and self-collision. It drives the packed 40-bit segment-coordinate buses read by `VGA_display` on every frame. It sits between the game-control FSM (start, tick, direction) and the display.

## Interface
- `MAX_LEN`, 10, number of segment slots (bus width = 4·MAX_LEN)
- `GRID_W`, 10, legal x cells 0..GRID_W-1
- `GRID_H`, 8, legal y cells 0..GRID_H-1
- `INIT_LEN`, 3, length after reset or start
- `clk  in  1`  system clock
- `rst  in  1`  reset: one clock, synchronous, active-high
- `start  in  1`  pulse; re-initialises the body and enters RUN
- `step  in  1`  move-tick pulse, one cycle wide
- `dir_in  in  2`  requested direction: 0 up, 1 right, 2 down, 3 left
- `dir_valid  in  1`  qualifies `dir_in`
- `fruit_x, fruit_y  in  4 each`  normal-fruit cell
- `poison_x, poison_y  in  4 each`  poison cell
- `snake_x_o, snake_y_o  out  40`  bits [4i+3:4i] hold segment i; segment 0 is the head
- `length_o  out  4`  current length, 1..MAX_LEN
- `eat_o  out  1`  one-cycle pulse: fruit eaten
- `poison_o  out  1`  one-cycle pulse: poison eaten
- `dead_o  out  1`  level signal, high while in DEAD
- `state_o  out  2`  0 IDLE, 1 RUN, 2 DEAD

## Operation
- **Init image** (applied by reset and by `start`):
  - Segment i = (INIT_LEN-1-i, 4) for i < INIT_LEN, giving head (2,4), then (1,4), (0,4).
  - All slots ≥ length are parked on the tail coordinate.
  - Direction = right; length = INIT_LEN.
- **Reset state:** IDLE with the init image loaded; `eat_o` = `poison_o` = `dead_o` = 0; `state_o` = 0.
- **FSM transitions:**
  - IDLE → RUN on `start`.
  - RUN → DEAD on a fatal step.
  - DEAD → RUN on `start` (init image reloaded).
  - `step` is ignored outside RUN.
- **Direction:**
  - `dir_valid` latches `dir_in` into `dir_r` unless it is the exact reverse of the committed direction. Reverse requests are dropped silently.
  - The committed direction takes `dir_r` on each step.
- **Step in RUN:**
  - Next head nh = head ± 1 on the committed axis.
  - Arithmetic is 5-bit signed, so moving left from x=0 or up from y=0 yields −1, which is out of range.
- **Fatal conditions** (evaluated on nh):
  - x ∉ [0, GRID_W-1] or y ∉ [0, GRID_H-1].
  - nh is a barrier cell: (3..6, 2).
  - nh equals any segment j < length, excluding the tail slot j = length-1 when that tail moves away this step (i.e. not growing).
  - On a fatal step: coordinates freeze, `dead_o` = 1, no eat or poison pulse.
- **Growth** (nh == fruit):
  - Shift with the tail kept, length + 1, saturating at MAX_LEN. At MAX_LEN the body moves normally.
  - `eat_o` pulses even when length is saturated.
- **Shrink** (nh == poison, not fruit):
  - Normal shift, then length − 1.
  - If length was 1, the step is fatal instead.
  - `poison_o` pulses.
- **Fruit and poison on the same cell:** fruit wins; poison is ignored.
- **Parking invariant:** after every update, slots ≥ length copy slot length-1, so the display never draws stale segments.

## Timing
- `step` sampled in cycle N; all outputs reflect the move from cycle N+1. All outputs are registered.
- `eat_o` / `poison_o` are high exactly in cycle N+1.
- `dir_valid` and `step` in the same cycle: the new direction applies to that step.
- `start` and `step` in the same cycle: `start` wins; the step is discarded.
- `rst` dominates everything, including mid-step. Outputs hold their reset values from the cycle after `rst` is sampled.
- Back-to-back `step` pulses (every cycle) must be supported with no bubbles.

## Structure
- Shared package `snake_pkg`:
  - direction encoding, state encoding
  - grid constants GRID_W, GRID_H
  - barrier cell list
  - init head (2,4)
- Sub-module `snake_next_head`: combinational nh computation plus wall and barrier checks. Self-collision and the shift register stay in `snake_body`.

## Test plan
- Reset, `start`, 3 steps right → head (5,4), body (4,4), (3,4); slots 3..9 = (3,4); `length_o` = 3.
- Fruit at (3,4), one step from init → `eat_o` pulse in cycle N+1, `length_o` = 4, slot 3 = (0,4).
- Request left while moving right → ignored. Then up, then step → head (2,3).
- Steer the head into (3,2) → `state_o` = 2, `dead_o` = 1, coordinates frozen; further steps change nothing; `start` reloads the init image.
- Poison at length 1 → DEAD. Poison at length 3 → `length_o` = 2, `poison_o` pulse.
- Grow to 10, eat again → `length_o` stays 10 and `eat_o` pulses. Head into its own body → DEAD. Head into the moving tail cell → survives.
